// File: rtl/nvm_channel_pkg.sv
// nvm_channel_pkg: shared Q11 format, level encodings, read references and packed-word layout
package nvm_channel_pkg;
   localparam int FRAC_BITS = 11;
   typedef enum logic [1:0] {
      LVL_0 = 2'd0,
      LVL_1 = 2'd1,
      LVL_2 = 2'd2,
      LVL_3 = 2'd3
   } level_e;
   localparam logic signed [15:0] REF1_DEF = 16'sd4915;
   localparam logic signed [15:0] REF2_DEF = 16'sd6144;
   localparam logic signed [15:0] REF3_DEF = 16'sd7373;
   localparam int VTH_MSB   = 31;
   localparam int VTH_LSB   = 16;
   localparam int ERASE_MSB = 15;
   localparam int ERASE_LSB = 2;
   localparam int LVL_MSB   = 1;
   localparam int LVL_LSB   = 0;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2
   } det_state_e;
endpackage

// File: rtl/vth_level_slicer.sv
// vth_level_slicer: hard decision of a signed Q11 read voltage into a 2-bit level
module vth_level_slicer
   import nvm_channel_pkg::*;
#(
   parameter logic signed [15:0] REF1 = REF1_DEF,
   parameter logic signed [15:0] REF2 = REF2_DEF,
   parameter logic signed [15:0] REF3 = REF3_DEF
) (
   input  logic signed [15:0] i_vd,
   output logic [1:0]         o_level
);
   // Levels sit in increasing-Vth order 0 < 2 < 3 < 1
   assign o_level = (i_vd < REF1) ? LVL_0 :
                    (i_vd < REF2) ? LVL_2 :
                    (i_vd < REF3) ? LVL_3 : LVL_1;
endmodule

// File: rtl/vth_read_detector.sv
// vth_read_detector: drift + hard read of programmed Vth, per-cell errors and per-frame error counts
module vth_read_detector
   import nvm_channel_pkg::*;
#(
   parameter logic signed [15:0] REF1 = REF1_DEF,
   parameter logic signed [15:0] REF2 = REF2_DEF,
   parameter logic signed [15:0] REF3 = REF3_DEF,
   parameter logic signed [15:0] DRIFT = 16'sd0,
   parameter int FRAME_LEN = 1024,
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_word,
   input  logic             start,
   input  logic             run_cont,
   output logic             det_valid,
   output logic [1:0]       det_level,
   output logic [1:0]       det_bit_err,
   output logic             frame_done,
   output logic [CNT_W-1:0] sym_err_frame,
   output logic [CNT_W-1:0] bit_err_frame,
   output logic             busy
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] SAT = '1;

   det_state_e r_state, w_next;
   logic r_s1_valid, r_s2_valid, r_s3_sym;
   logic [1:0] r_s1_lvl, r_s2_lvl, r_s2_det;
   logic signed [15:0] r_s1_vd, w_vd;
   logic signed [16:0] w_diff;
   logic [1:0] w_det, w_xor;
   logic [CW-1:0] r_cell_cnt;
   logic [CNT_W-1:0] r_sym_acc, r_bit_acc, w_sym_new, w_bit_new;
   logic [CNT_W:0] w_sym_sum, w_bit_sum;
   logic w_count, w_last;
   logic w_unused_erase;

   assign w_unused_erase = ^in_word[ERASE_MSB:ERASE_LSB];

   // Saturate the drifted voltage instead of letting it wrap
   assign w_diff = {in_word[VTH_MSB], in_word[VTH_MSB:VTH_LSB]} - {DRIFT[15], DRIFT};
   assign w_vd = (w_diff[16] != w_diff[15]) ? (w_diff[16] ? 16'sh8000 : 16'sh7fff) : w_diff[15:0];
   assign w_xor = r_s2_det ^ r_s2_lvl;

   vth_level_slicer #(.REF1(REF1), .REF2(REF2), .REF3(REF3)) u_slicer (
      .i_vd    (r_s1_vd),
      .o_level (w_det)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_lvl    <= 2'd0;
         r_s1_vd     <= 16'sd0;
         r_s2_valid  <= 1'b0;
         r_s2_lvl    <= 2'd0;
         r_s2_det    <= 2'd0;
         det_valid   <= 1'b0;
         det_level   <= 2'd0;
         det_bit_err <= 2'd0;
         r_s3_sym    <= 1'b0;
      end else begin
         r_s1_valid  <= in_valid;
         r_s1_lvl    <= in_word[LVL_MSB:LVL_LSB];
         r_s1_vd     <= w_vd;
         r_s2_valid  <= r_s1_valid;
         r_s2_lvl    <= r_s1_lvl;
         r_s2_det    <= w_det;
         det_valid   <= r_s2_valid;
         det_level   <= r_s2_det;
         det_bit_err <= {1'b0, w_xor[1]} + {1'b0, w_xor[0]};
         r_s3_sym    <= |w_xor;
      end
   end

   // A REPORT-cycle cell opens the next frame only when the FSM continues to RUN
   assign w_count = det_valid && (r_state == ST_RUN || (r_state == ST_REPORT && run_cont));
   assign w_last = (r_state == ST_RUN) && w_count && (r_cell_cnt == LAST);
   assign w_sym_sum = {1'b0, r_sym_acc} + (CNT_W + 1)'(r_s3_sym);
   assign w_bit_sum = {1'b0, r_bit_acc} + (CNT_W + 1)'(det_bit_err);
   assign w_sym_new = w_sym_sum[CNT_W] ? SAT : w_sym_sum[CNT_W-1:0];
   assign w_bit_new = w_bit_sum[CNT_W] ? SAT : w_bit_sum[CNT_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = (r_state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
               (r_state == ST_RUN)  ? (w_last ? ST_REPORT : ST_RUN) :
               (run_cont ? ST_RUN : ST_IDLE);
   end

   always_comb begin
      frame_done = (r_state == ST_REPORT);
      busy = (r_state != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cell_cnt    <= '0;
         r_sym_acc     <= '0;
         r_bit_acc     <= '0;
         sym_err_frame <= '0;
         bit_err_frame <= '0;
      end else begin
         if (w_last) begin
            sym_err_frame <= w_sym_new;
            bit_err_frame <= w_bit_new;
         end
         if (r_state == ST_IDLE || w_last) begin
            r_cell_cnt <= '0;
            r_sym_acc  <= '0;
            r_bit_acc  <= '0;
         end else if (w_count) begin
            r_cell_cnt <= r_cell_cnt + 1'b1;
            r_sym_acc  <= w_sym_new;
            r_bit_acc  <= w_bit_new;
         end
      end
   end
endmodule

// File: tb/tb_vth_read_detector.sv
// tb_vth_read_detector: directed checks of detection, drift saturation and frame statistics
module tb_vth_read_detector;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic start = 1'b0;
   logic run_cont = 1'b0;
   logic [31:0] in_word = 32'd0;
   logic det_valid, frame_done, busy;
   logic [1:0] det_level, det_bit_err;
   logic [19:0] sym_err_frame, bit_err_frame;
   logic dr_valid, dr_done, dr_busy;
   logic [1:0] dr_level, dr_err;
   logic [19:0] dr_sym, dr_bit;
   int checks = 0;
   int errors = 0;

   localparam int NV = 10;
   logic signed [15:0] lv_vth [NV] = '{16'sd5300, 16'sd4900, 16'sd7400, -16'sd100, 16'sd5500,
                                       16'sd4915, 16'sd4914, 16'sd6144, 16'sd7373, 16'sd7372};
   logic [1:0] lv_lvl [NV] = '{2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd3};
   logic [1:0] ex_lvl [NV] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd3};
   logic [1:0] ex_err [NV] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
   logic [1:0] ex_drl [NV] = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3};

   always #5 clk = ~clk;

   vth_read_detector #(.FRAME_LEN(4), .CNT_W(20)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .start(start),
      .run_cont(run_cont), .det_valid(det_valid), .det_level(det_level), .det_bit_err(det_bit_err),
      .frame_done(frame_done), .sym_err_frame(sym_err_frame), .bit_err_frame(bit_err_frame), .busy(busy)
   );

   vth_read_detector #(.DRIFT(16'sd200), .FRAME_LEN(4), .CNT_W(20)) u_drift (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .start(1'b0),
      .run_cont(1'b0), .det_valid(dr_valid), .det_level(dr_level), .det_bit_err(dr_err),
      .frame_done(dr_done), .sym_err_frame(dr_sym), .bit_err_frame(dr_bit), .busy(dr_busy)
   );

   function automatic logic [31:0] mk(input logic [15:0] v, input logic [1:0] l);
      return {v, 14'h1a5c, l};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({det_valid, det_level, det_bit_err, frame_done, busy} !== 7'd0) begin
         errors++; $display("FAIL reset_det got %b want 0", {det_valid, det_level, det_bit_err, frame_done, busy});
      end
      checks++;
      if ({sym_err_frame, bit_err_frame} !== 40'd0) begin
         errors++; $display("FAIL reset_report got %0d/%0d want 0/0", sym_err_frame, bit_err_frame);
      end
      reset = 1'b0;
   endtask

   task automatic test_levels();
      for (int k = 0; k < NV; k++) begin
         in_valid = 1'b1;
         in_word = mk(lv_vth[k], lv_lvl[k]);
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(posedge clk);
         #1;
         checks++;
         if (det_valid !== 1'b0) begin
            errors++; $display("FAIL early_valid[%0d] got %b want 0", k, det_valid);
         end
         @(posedge clk);
         #1;
         checks++;
         if (det_valid !== 1'b1) begin
            errors++; $display("FAIL lvl_valid[%0d] got %b want 1", k, det_valid);
         end
         checks++;
         if (det_level !== ex_lvl[k]) begin
            errors++; $display("FAIL lvl_level[%0d] got %0d want %0d", k, det_level, ex_lvl[k]);
         end
         checks++;
         if (det_bit_err !== ex_err[k]) begin
            errors++; $display("FAIL lvl_biterr[%0d] got %0d want %0d", k, det_bit_err, ex_err[k]);
         end
         checks++;
         if (dr_level !== ex_drl[k]) begin
            errors++; $display("FAIL drift_level[%0d] got %0d want %0d", k, dr_level, ex_drl[k]);
         end
      end
   endtask

   task automatic test_saturation();
      logic signed [15:0] sv [2] = '{-16'sd32700, 16'sd32767};
      logic [1:0] want_main [2] = '{2'd0, 2'd1};
      logic [1:0] want_dr [2] = '{2'd0, 2'd1};
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_word = mk(sv[k], 2'd0);
         @(posedge clk);
         #1 in_valid = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         checks++;
         if (det_level !== want_main[k]) begin
            errors++; $display("FAIL sat_main[%0d] got %0d want %0d", k, det_level, want_main[k]);
         end
         checks++;
         if (dr_level !== want_dr[k] || dr_valid !== 1'b1) begin
            errors++; $display("FAIL sat_drift[%0d] got %0d/%b want %0d/1", k, dr_level, dr_valid, want_dr[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NV + 3; i++) begin
         in_valid = (i < NV);
         in_word = (i < NV) ? mk(lv_vth[i], lv_lvl[i]) : 32'd0;
         @(posedge clk);
         #1;
         if (i >= 2 && i - 2 < NV) begin
            checks++;
            if (det_valid !== 1'b1 || det_level !== ex_lvl[i-2] || det_bit_err !== ex_err[i-2]) begin
               errors++;
               $display("FAIL b2b[%0d] got v%b l%0d e%0d want v1 l%0d e%0d", i - 2, det_valid, det_level, det_bit_err, ex_lvl[i-2], ex_err[i-2]);
            end
         end else if (i >= 2) begin
            checks++;
            if (det_valid !== 1'b0) begin
               errors++; $display("FAIL b2b_tail got %b want 0", det_valid);
            end
         end
      end
   endtask

   task automatic test_frame();
      logic [15:0] fv [4] = '{16'd5300, 16'd4900, 16'd5500, 16'd5300};
      logic [1:0] fl [4] = '{2'd2, 2'd2, 2'd1, 2'd2};
      int pulses = 0, at = -1;
      logic [19:0] gs = '0, gb = '0;
      run_cont = 1'b0;
      for (int i = 0; i < 14; i++) begin
         start = (i == 0);
         in_valid = (i >= 1 && i <= 4);
         in_word = (i >= 1 && i <= 4) ? mk(fv[i-1], fl[i-1]) : 32'd0;
         @(posedge clk);
         #1;
         if (frame_done) begin pulses++; at = i; gs = sym_err_frame; gb = bit_err_frame; end
         if (i == 1) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %b want 1", busy); end
         end
      end
      checks++;
      if (pulses != 1 || at != 7) begin errors++; $display("FAIL frame_pulse got %0d@%0d want 1@7", pulses, at); end
      checks++;
      if (gs !== 20'd2 || gb !== 20'd3) begin errors++; $display("FAIL frame_report got %0d/%0d want 2/3", gs, gb); end
      checks++;
      if (busy !== 1'b0 || sym_err_frame !== 20'd2) begin
         errors++; $display("FAIL frame_after got busy %b sym %0d want 0/2", busy, sym_err_frame);
      end
   endtask

   task automatic test_start_same_cycle();
      int pulses = 0, at = -1;
      logic [19:0] gs = '0, gb = '0;
      run_cont = 1'b0;
      for (int i = 0; i < 12; i++) begin
         start = (i == 0 || i == 2 || i == 7);
         in_valid = (i <= 3);
         in_word = (i == 0) ? mk(16'd5500, 2'd1) : mk(16'd5300, 2'd2);
         @(posedge clk);
         #1;
         if (frame_done) begin pulses++; at = i; gs = sym_err_frame; gb = bit_err_frame; end
         if (i == 7) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL start_in_report got busy %b want 0", busy); end
         end
      end
      start = 1'b0;
      checks++;
      if (pulses != 1 || at != 6) begin errors++; $display("FAIL same_cycle_pulse got %0d@%0d want 1@6", pulses, at); end
      checks++;
      if (gs !== 20'd1 || gb !== 20'd2) begin errors++; $display("FAIL same_cycle_report got %0d/%0d want 1/2", gs, gb); end
   endtask

   task automatic test_cont_and_abort();
      int pulses = 0;
      int p_at [3] = '{-1, -1, -1};
      logic [19:0] p_sym [3] = '{20'hfffff, 20'hfffff, 20'hfffff};
      logic [19:0] p_bit [3] = '{20'hfffff, 20'hfffff, 20'hfffff};
      int want_at [3] = '{7, 11, 15};
      logic [19:0] want_sym [3] = '{20'd0, 20'd0, 20'd1};
      run_cont = 1'b1;
      for (int i = 0; i < 20; i++) begin
         start = (i == 0);
         in_valid = (i >= 1 && i <= 12) || i == 17 || i == 18;
         in_word = (i == 9 || i >= 17) ? mk(16'd4900, 2'd2) : mk(16'd5300, 2'd2);
         @(posedge clk);
         #1;
         if (frame_done) begin
            if (pulses < 3) begin p_at[pulses] = i; p_sym[pulses] = sym_err_frame; p_bit[pulses] = bit_err_frame; end
            pulses++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (pulses != 3) begin errors++; $display("FAIL cont_pulses got %0d want 3", pulses); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (p_at[k] != want_at[k] || p_sym[k] !== want_sym[k] || p_bit[k] !== want_sym[k]) begin
            errors++;
            $display("FAIL cont_report[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, p_at[k], p_sym[k], p_bit[k], want_at[k], want_sym[k], want_sym[k]);
         end
      end
      checks++;
      if (busy !== 1'b1 || det_valid !== 1'b1) begin
         errors++; $display("FAIL pre_abort got busy %b valid %b want 1/1", busy, det_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({det_valid, det_level, det_bit_err, frame_done, busy} !== 7'd0 || {sym_err_frame, bit_err_frame} !== 40'd0) begin
         errors++;
         $display("FAIL abort_async got v%b l%0d e%0d fd%b b%b %0d/%0d want all 0", det_valid, det_level, det_bit_err, frame_done, busy, sym_err_frame, bit_err_frame);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      run_cont = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (frame_done) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_after got pulses %0d busy %b want 0/0", pulses, busy);
      end
   endtask

   initial begin
      test_reset();
      test_levels();
      test_saturation();
      test_back_to_back();
      test_frame();
      test_start_same_cycle();
      test_cont_and_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
